disparity_sink: RTL and testbench
=================================

DISPARITY_SINK -- requirements
Module: disparity_sink

Interface
REQ-001 Parameter THRESH, default 8'd24: maximum omin-equivalent cost accepted as a confident match.
REQ-002 Parameter DEPTH, default 16: output FIFO entries, power of two.
REQ-003 Parameter XLO, default 10'd64: first valid output column (disparity range offset).
REQ-004 Parameter XHI, default 10'd639: last valid output column.
REQ-005 Parameter YHI, default 10'd479: last valid row.
REQ-006 clk  in  1  single clock for the whole block.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 ivalid  in  1  one disparity sample is present this cycle.
REQ-009 imin  in  8  aggregated winning cost from the disparity stage.
REQ-010 iargmin  in  8  winning disparity index, legal 0..63.
REQ-011 ix  in  10  output column from the disparity stage (input x+64).
REQ-012 iy  in  10  output row.
REQ-013 odata  out  8  disparity pixel, 0 = invalid.
REQ-014 osof  out  1  odata is pixel (XLO,0).
REQ-015 oeol  out  1  odata is last pixel of a line (ix==XHI).
REQ-016 ovalid  out  1  odata/osof/oeol valid.
REQ-017 ordy  in  1  downstream accepts the word when ovalid&&ordy.
REQ-018 ooverflow  out  1  sticky: a sample was dropped on a full FIFO.
REQ-019 obad_count  out  16  invalid-pixel count of the last completed frame.
REQ-020 oframe_done  out  1  one-cycle pulse when obad_count updates.

Function
REQ-021 A sample SHALL be "in window" when ivalid && XLO<=ix<=XHI && iy<=YHI; all other samples are ignored without side effects.
REQ-022 FSM states IDLE and RUN; IDLE->RUN on an in-window sample at (XLO,0), which is itself accepted; RUN->IDLE after accepting (XHI,YHI); all samples in IDLE except (XLO,0) are dropped and not counted.
REQ-023 An accepted sample SHALL be invalid when imin>THRESH or iargmin>63; invalid -> odata 8'd0, else odata = iargmin<<2 (0..252, no overflow).
REQ-024 osof=1 for (XLO,0); oeol=1 when ix==XHI.
REQ-025 Pipeline: sample registered at edge N, written to FIFO at edge N+1; with FIFO previously empty, ovalid is high in the cycle after edge N+1 (2-cycle latency).
REQ-026 FIFO is show-ahead: odata/osof/oeol reflect the head entry whenever ovalid=1; ovalid = FIFO not empty.
REQ-027 Pop on ovalid&&ordy; push and pop in the same cycle SHALL both occur, including when full (count unchanged).
REQ-028 Push when full without pop: word discarded, FIFO contents unchanged, ooverflow set and held until rst.
REQ-029 Pointers wrap modulo DEPTH; order of words SHALL be preserved across wrap.
REQ-030 Running bad counter increments on each accepted invalid sample, saturating at 16'hFFFF.
REQ-031 On acceptance of (XHI,YHI): obad_count <= running count including that sample, running count <= 0, oframe_done=1 for exactly one cycle, aligned with the edge that registers the sample.
REQ-032 An (XLO,0) sample while in RUN SHALL restart the frame: running count cleared, sample accepted, no oframe_done.
REQ-033 ordy deasserted with ovalid=1: head word and ovalid SHALL hold unchanged.

Reset
REQ-034 On rst=1 at an edge: FSM IDLE, FIFO empty, pipeline register cleared, running count 0.
REQ-035 Reset values: odata 0, osof 0, oeol 0, ovalid 0, ooverflow 0, obad_count 0, oframe_done 0.
REQ-036 rst mid-frame SHALL discard all buffered and in-flight samples; none appear after rst deasserts.

Verification
REQ-037 ordy=1, samples (64,0) imin=5 argmin=10, (65,0) imin=30 argmin=7 -> odata 40 osof=1, then odata 0 osof=0; first ovalid 2 cycles after first sample.
REQ-038 Sample (700,0) and (64,480) only -> ovalid stays 0, bad count unchanged.
REQ-039 ordy=0, 20 consecutive in-window samples, DEPTH=16 -> 16 words held, ooverflow=1; ordy=1 -> exactly 16 words out in order, ooverflow stays 1.
REQ-040 Full frame 576x480 with 100 samples imin=200 -> oframe_done one pulse after (639,479), obad_count=100, FSM IDLE.
REQ-041 FIFO full, ordy=1, continuous input -> no drop, ooverflow=0, count steady.
REQ-042 rst asserted with 8 words buffered -> next cycle ovalid=0, all outputs 0; resumed stream ignored until (64,0).

Source files
------------

// File: rtl/disparity_sink_if.sv
// rtl/disparity_sink_if.sv - disparity sample input and pixel output stream bundle
interface disparity_sink_if;
    logic       ivalid;
    logic [7:0] imin;
    logic [7:0] iargmin;
    logic [9:0] ix;
    logic [9:0] iy;
    logic [7:0] odata;
    logic       osof;
    logic       oeol;
    logic       ovalid;
    logic       ordy;

    modport master (
        output ivalid, imin, iargmin, ix, iy, ordy,
        input  odata, osof, oeol, ovalid
    );

    modport slave (
        input  ivalid, imin, iargmin, ix, iy, ordy,
        output odata, osof, oeol, ovalid
    );
endinterface

// File: rtl/disparity_sink.sv
// rtl/disparity_sink.sv - disparity confidence filter, frame tracker and show-ahead output FIFO
module disparity_sink #(
    parameter logic [7:0] THRESH = 8'd24,
    parameter int         DEPTH  = 16,
    parameter logic [9:0] XLO    = 10'd64,
    parameter logic [9:0] XHI    = 10'd639,
    parameter logic [9:0] YHI    = 10'd479
) (
    input  logic                 clk,
    input  logic                 rst,
    disparity_sink_if.slave      s,
    output logic                 ooverflow,
    output logic [15:0]          obad_count,
    output logic                 oframe_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic        in_win, at_sof, at_last, bad;
    logic        accept, frame_end;
    logic [15:0] run_cnt, cnt_base, cnt_next;
    logic        p_valid;
    logic [9:0]  p_word;

    assign in_win  = s.ivalid && (s.ix >= XLO) && (s.ix <= XHI) && (s.iy <= YHI);
    assign at_sof  = in_win && (s.ix == XLO) && (s.iy == 10'd0);
    assign at_last = in_win && (s.ix == XHI) && (s.iy == YHI);
    assign bad     = (s.imin > THRESH) || (s.iargmin > 8'd63);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (at_sof && !at_last) state_d = RUN;
            RUN:  if (at_last)            state_d = IDLE;
        endcase
    end

    always_comb begin
        accept    = in_win && ((state_q == RUN) || at_sof);
        frame_end = accept && at_last;
    end

    // A start-of-frame sample always begins a fresh count, even mid-frame.
    assign cnt_base = at_sof ? 16'd0 : run_cnt;
    assign cnt_next = (bad && (cnt_base != 16'hFFFF)) ? cnt_base + 16'd1 : cnt_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt     <= 16'd0;
            obad_count  <= 16'd0;
            oframe_done <= 1'b0;
        end else begin
            oframe_done <= frame_end;
            if (accept) begin
                if (frame_end) begin
                    obad_count <= cnt_next;
                    run_cnt    <= 16'd0;
                end else begin
                    run_cnt    <= cnt_next;
                end
            end
        end
    end

    // Word layout: {sof, eol, pixel}
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_word  <= 10'd0;
        end else begin
            p_valid <= accept;
            p_word  <= {at_sof, s.ix == XHI, bad ? 8'd0 : {s.iargmin[5:0], 2'b00}};
        end
    end

    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;
    logic [9:0]  head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && s.ordy;
    assign push  = p_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= p_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ooverflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (p_valid && full && !pop) ooverflow <= 1'b1;
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign s.ovalid = !empty;
    assign s.odata  = empty ? 8'd0 : head[7:0];
    assign s.osof   = !empty && head[9];
    assign s.oeol   = !empty && head[8];
endmodule

// File: tb/tb_disparity_sink.sv
// tb/tb_disparity_sink.sv - randomized scoreboard bench for disparity_sink
module tb_disparity_sink;
    localparam int         DEPTH  = 16;
    localparam logic [7:0] THRESH = 8'd24;
    localparam logic [9:0] XLO    = 10'd64;
    localparam logic [9:0] XHI    = 10'd79;
    localparam logic [9:0] YHI    = 10'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ooverflow;
    logic [15:0] obad_count;
    logic        oframe_done;

    disparity_sink_if bus();

    disparity_sink #(.THRESH(THRESH), .DEPTH(DEPTH), .XLO(XLO), .XHI(XHI), .YHI(YHI)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus.slave),
        .ooverflow  (ooverflow),
        .obad_count (obad_count),
        .oframe_done(oframe_done)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] sb[$];
    logic [9:0] mon_exp;
    bit         in_frame = 0;
    int         run_bad  = 0;
    int         exp_bad  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.ovalid && bus.ordy) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                check("odata", bus.odata, mon_exp[7:0]);
                check("osof",  bus.osof,  mon_exp[9]);
                check("oeol",  bus.oeol,  mon_exp[8]);
            end
        end
    end

    // Reference: frame membership, confidence test and bad tally from the pixel rules.
    task automatic cycle(input bit v, input int x, input int y, input int mn, input int am,
                         input bit track_full);
        bit win, sofp, lastp, acc, bad, done;
        int data;
        win   = v && x >= XLO && x <= XHI && y <= YHI;
        sofp  = win && x == XLO && y == 0;
        lastp = win && x == XHI && y == YHI;
        acc   = win && (in_frame || sofp);
        bad   = mn > THRESH || am > 63;
        done  = 0;
        if (acc) begin
            if (sofp) begin
                in_frame = 1;
                run_bad  = 0;
            end
            if (bad && run_bad < 65535) run_bad++;
            data = bad ? 0 : am * 4;
            if (!(track_full && sb.size() >= DEPTH)) sb.push_back({sofp, x == XHI, data[7:0]});
            if (lastp) begin
                in_frame = 0;
                exp_bad  = run_bad;
                run_bad  = 0;
                done     = 1;
            end
        end
        bus.ivalid  = v;
        bus.ix      = x[9:0];
        bus.iy      = y[9:0];
        bus.imin    = mn[7:0];
        bus.iargmin = am[7:0];
        @(posedge clk);
        #1;
        check("oframe_done", oframe_done, done);
        check("obad_count", obad_count, exp_bad);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic seq(input int first, input int n, input bit track_full);
        for (int i = first; i < first + n; i++)
            cycle(1, XLO + i % 16, i / 16, $urandom_range(0, 48), $urandom_range(0, 70), track_full);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ivalid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        in_frame = 0;
        run_bad  = 0;
        exp_bad  = 0;
        check("rst_ovalid", bus.ovalid, 0);
        check("rst_odata", bus.odata, 0);
        check("rst_osof", bus.osof, 0);
        check("rst_oeol", bus.oeol, 0);
        check("rst_ooverflow", ooverflow, 0);
        check("rst_obad_count", obad_count, 0);
        check("rst_oframe_done", oframe_done, 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.ordy = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 0; i++) idle(1);
        check("drain_left", sb.size(), 0);
        idle(3);
    endtask

    initial begin
        int r, x, y, mn, am;
        bit v;
        bus.ivalid = 0; bus.imin = 0; bus.iargmin = 0; bus.ix = 0; bus.iy = 0; bus.ordy = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Two samples, checking the two-cycle latency.
        bus.ordy = 1'b1;
        cycle(1, 64, 0, 5, 10, 0);
        check("lat_edge_n", bus.ovalid, 0);
        cycle(1, 65, 0, 30, 7, 0);
        check("lat_edge_n1", bus.ovalid, 1);
        drain();

        // Out-of-window samples only.
        do_reset();
        cycle(1, 700, 0, 200, 5, 0);
        cycle(1, 64, 480, 200, 5, 0);
        idle(4);
        check("oow_ovalid", bus.ovalid, 0);
        check("oow_bad", obad_count, 0);

        // Overflow with ordy low.
        do_reset();
        bus.ordy = 1'b0;
        seq(0, 20, 1);
        idle(3);
        check("ovf_flag", ooverflow, 1);
        check("ovf_ovalid", bus.ovalid, 1);
        drain();
        check("ovf_sticky", ooverflow, 1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        bus.ordy = 1'b0;
        seq(0, 16, 1);
        idle(2);
        bus.ordy = 1'b1;
        seq(16, 40, 0);
        drain();
        check("full_stream_ovf", ooverflow, 0);

        // Complete frame with 100 bad pixels.
        do_reset();
        bus.ordy = 1'b1;
        for (int i = 0; i < 128; i++)
            cycle(1, XLO + i % 16, i / 16, (i < 100) ? 200 : $urandom_range(0, 24),
                  $urandom_range(0, 63), 0);
        drain();
        check("frame_bad", obad_count, 100);
        cycle(1, 65, 0, 5, 5, 0);
        idle(3);
        check("frame_idle", bus.ovalid, 0);

        // Reset with buffered words, then resume.
        do_reset();
        bus.ordy = 1'b0;
        seq(0, 8, 1);
        idle(2);
        check("pre_rst_ovalid", bus.ovalid, 1);
        do_reset();
        bus.ordy = 1'b1;
        cycle(1, 65, 0, 5, 5, 0);
        cycle(1, 66, 0, 5, 5, 0);
        idle(2);
        check("post_rst_idle", bus.ovalid, 0);
        cycle(1, 64, 0, 5, 3, 0);
        drain();

        // Randomized traffic with restarts, stray samples and random back-pressure.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.ordy = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 99);
            v  = 1;
            x  = $urandom_range(XLO, XHI);
            y  = $urandom_range(0, YHI);
            mn = $urandom_range(0, 48);
            am = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 63);
            if (r < 3) begin
                x = XLO; y = 0;
            end else if (r < 8) begin
                x = XHI; y = YHI;
            end else if (r < 12) begin
                x = $urandom_range(XHI + 1, 1023);
            end else if (r < 15) begin
                y = $urandom_range(YHI + 1, 1023);
            end else if (r < 20) begin
                v = 0;
            end
            if (sb.size() >= DEPTH) v = 0;
            cycle(v, x, y, mn, am, 0);
        end
        drain();
        check("rand_ovf", ooverflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
